// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - execute-stage ALU with a start/busy/valid handshake and 1-bit/cycle shifts.
// Optional macro ALU_FAST_SHIFT_EN: single-cycle barrel shifter, the SHIFT state is never entered.
module alu_seq_exec #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         ALU_Selection,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               valid,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic               accept;
  logic               go_shift;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;

  assign shamt  = B[SHAMT_W-1:0];
  assign accept = start && (state == IDLE);
  assign busy   = (state != IDLE);
  assign valid  = (state == DONE);
  assign zero   = (result == '0);

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_step;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         op_q;

  // Zero-amount shifts finish in one cycle like any other op.
  assign go_shift = ((ALU_Selection == 4'b0100) || (ALU_Selection == 4'b0101) ||
                     (ALU_Selection == 4'b0111)) && (shamt != '0);

  always_comb begin
    acc_step = acc;
    case (op_q)
      2'b00:   acc_step = acc << 1;
      2'b01:   acc_step = acc >> 1;
      default: acc_step = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end
`endif

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALU_Selection)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = A + B;
      4'b0110: alu_res = A - B;
      4'b0011: alu_res = A ^ B;
`ifdef ALU_FAST_SHIFT_EN
      4'b0100: alu_res = A << shamt;
      4'b0101: alu_res = A >> shamt;
      4'b0111: alu_res = $signed(A) >>> shamt;
`else
      4'b0100, 4'b0101, 4'b0111: alu_res = A;
`endif
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = go_shift ? SHIFT : DONE;
`ifdef ALU_FAST_SHIFT_EN
      SHIFT: state_next = IDLE;
`else
      SHIFT: if (cnt == SHAMT_W'(1)) state_next = DONE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // result/illegal change only when an op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      illegal <= 1'b0;
`ifdef ALU_FAST_SHIFT_EN
`else
      acc     <= '0;
      cnt     <= '0;
      op_q    <= 2'b00;
`endif
    end else if (accept && !go_shift) begin
      result  <= alu_res;
      illegal <= alu_ill;
    end
`ifdef ALU_FAST_SHIFT_EN
`else
    else if (accept) begin
      acc  <= A;
      cnt  <= shamt;
      op_q <= ALU_Selection[1:0];
    end else if (state == SHIFT) begin
      acc <= acc_step;
      cnt <= cnt - 1'b1;
      if (cnt == SHAMT_W'(1)) begin
        result  <= acc_step;
        illegal <= 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - scoreboard bench for alu_seq_exec with directed vectors.
module tb_alu_seq_exec;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    time         t;
  } exp_t;

  exp_t sb[$];

  alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_Selection(sel),
    .A(op_a), .B(op_b), .busy(busy), .valid(valid), .result(result),
    .zero(zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid pulse.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: actual result=0x%08h expected no valid", result);
      end else begin
        exp_t e;
        int   lat;
        e = sb.pop_front();
        lat = int'(($time - e.t - 5) / 10) + 1;
        check("result", result, e.res);
        check("illegal", {31'b0, illegal}, {31'b0, e.ill});
        check("zero", {31'b0, zero}, {31'b0, (e.res == 32'h0)});
        check("latency", lat, e.lat);
      end
    end
  end

  // Shift latency differs between builds.
  function automatic int shift_lat(input int n);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : 1 + n;
`endif
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ill, input int exp_lat,
                       input bit poke);
    int busy_cnt = 0;
    @(negedge clk);
    sel = op; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    sb.push_back('{exp_res, exp_ill, exp_lat, $time});
    #1 start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      if (poke && busy_cnt == 3) begin
        sel = 4'b0010; op_a = 32'h11; op_b = 32'h22; start = 1'b1;
      end
      if (poke && busy_cnt == 4) start = 1'b0;
    end
    check("busy_cycles", busy_cnt, exp_lat);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sel = 4'h0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    rst_n = 1'b1;

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1, 1'b0);
    issue(4'b0110, 32'h5,         32'h5,         32'h0,         1'b0, 1, 1'b0);
    issue(4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 1'b0);
    issue(4'b1001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 1'b0);
    issue(4'b1000, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0, 1, 1'b0);
    issue(4'b1001, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1, 1'b0);
    issue(4'b0000, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1, 1'b0);
    issue(4'b0001, 32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0, 1, 1'b0);
    issue(4'b0011, 32'hFF,        32'h0F,        32'hF0,        1'b0, 1, 1'b0);
    issue(4'b0111, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0, shift_lat(4), 1'b0);
    issue(4'b0100, 32'h1,         32'h0,         32'h1,         1'b0, 1, 1'b0);
    issue(4'b0101, 32'hF0,        32'h4,         32'h0F,        1'b0, shift_lat(4), 1'b0);
    issue(4'b0100, 32'h1,         32'd31,        32'h8000_0000, 1'b0, shift_lat(31), 1'b1);
    issue(4'b1111, 32'h1234,      32'h5678,      32'h0,         1'b1, 1, 1'b0);
    issue(4'b1010, 32'h1,         32'h1,         32'h0,         1'b1, 1, 1'b0);
    issue(4'b0010, 32'h1,         32'h1,         32'h2,         1'b0, 1, 1'b0);

    // Reset in the middle of a long shift: nothing may complete.
    @(negedge clk);
    sel = 4'b0100; op_a = 32'h1; op_b = 32'd10; start = 1'b1;
    @(posedge clk);
    `ifdef ALU_FAST_SHIFT_EN
    sb.push_back('{32'h400, 1'b0, 1, $time});
    `endif
    #1 start = 1'b0;
    `ifdef ALU_FAST_SHIFT_EN
    repeat (3) @(negedge clk);
    `else
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_valid", {31'b0, valid}, 32'h0);
    check("midrst_zero", {31'b0, zero}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    `endif
    issue(4'b0010, 32'h2, 32'h3, 32'h5, 1'b0, 1, 1'b0);

    // start held high: accepts on alternate edges because DONE blocks.
    @(negedge clk);
    sel = 4'b0010; op_a = 32'h1; op_b = 32'h1; start = 1'b1;
    @(posedge clk);
    sb.push_back('{32'h2, 1'b0, 1, $time});
    @(posedge clk);
    @(posedge clk);
    sb.push_back('{32'h2, 1'b0, 1, $time});
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);

    check("scoreboard_empty", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
